// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register numbers, field positions, PRId and handler address.
package cp0_pkg;

  localparam logic [4:0] RegSr    = 5'd12;
  localparam logic [4:0] RegCause = 5'd13;
  localparam logic [4:0] RegEpc   = 5'd14;
  localparam logic [4:0] RegPrid  = 5'd15;

  localparam int unsigned SrImLo     = 10;
  localparam int unsigned SrExl      = 1;
  localparam int unsigned SrIe       = 0;
  localparam int unsigned CauseBd    = 31;
  localparam int unsigned CauseIpLo  = 10;
  localparam int unsigned CauseExcLo = 2;

  localparam logic [31:0] PridValue   = 32'h2019_1119;
  localparam logic [31:0] HandlerAddr = 32'h0000_4180;

  function automatic logic [31:0] pack_sr(logic [5:0] im, logic exl, logic ie);
    logic [31:0] w;
    w = '0;
    w[SrImLo +: 6] = im;
    w[SrExl]       = exl;
    w[SrIe]        = ie;
    return w;
  endfunction

  function automatic logic [31:0] pack_cause(logic bd, logic [5:0] ip, logic [4:0] exc);
    logic [31:0] w;
    w = '0;
    w[CauseBd]         = bd;
    w[CauseIpLo +: 6]  = ip;
    w[CauseExcLo +: 5] = exc;
    return w;
  endfunction

endpackage

// File: rtl/cp0_if.sv
// Pipeline-to-CP0 signal bundle; master is the pipeline, slave is CP0.
interface cp0_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        We;
  logic [31:0] PC;
  logic        BD;
  logic        ExcReq;
  logic [4:0]  ExcCode;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPC;
  logic [31:0] DOut;

  modport master (
    output A1, A2, DIn, We, PC, BD, ExcReq, ExcCode, HWInt, EXLClr,
    input  IntReq, EPC, DOut
  );

  modport slave (
    input  A1, A2, DIn, We, PC, BD, ExcReq, ExcCode, HWInt, EXLClr,
    output IntReq, EPC, DOut
  );
endinterface

// File: rtl/cp0_int_arb.sv
// Interrupt/exception arbiter: pending interrupt, request and selected exception code.
module cp0_int_arb (
  input  logic [5:0] hw_int,
  input  logic [5:0] im,
  input  logic       ie,
  input  logic       exl,
  input  logic       exc_req,
  input  logic [4:0] exc_code,
  output logic       int_pend,
  output logic       int_req,
  output logic [4:0] exc_code_sel
);

  always_comb begin
    int_pend     = (|(hw_int & im)) & ie;
    int_req      = (int_pend | exc_req) & ~exl;
    // Interrupts take priority and report code 0.
    exc_code_sel = int_pend ? 5'd0 : exc_code;
  end

endmodule

// File: rtl/cp0.sv
// Coprocessor 0: SR, Cause, EPC, PRId and exception entry/return.
// Optional feature: define CP0_BD_EN to record delay-slot state in Cause.BD and rewind EPC.
module cp0
  import cp0_pkg::*;
(
  input logic    clk,
  input logic    reset,
  cp0_if.slave   bus
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic        int_pend;
  logic        int_req;
  logic [4:0]  exc_code_sel;
  logic [31:0] pc_aligned;

  cp0_int_arb u_int_arb (
    .hw_int       (bus.HWInt),
    .im           (im_q),
    .ie           (ie_q),
    .exl          (exl_q),
    .exc_req      (bus.ExcReq),
    .exc_code     (bus.ExcCode),
    .int_pend     (int_pend),
    .int_req      (int_req),
    .exc_code_sel (exc_code_sel)
  );

  assign pc_aligned = bus.PC & 32'hFFFF_FFFC;

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = bus.HWInt;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;

    if (int_req) begin
      exl_d      = 1'b1;
      exc_code_d = exc_code_sel;
`ifdef CP0_BD_EN
      bd_d       = bus.BD;
      epc_d      = bus.BD ? (pc_aligned - 32'd4) : pc_aligned;
`else
      // BD is ignored in this build; Cause.BD stays 0.
      bd_d       = bus.BD & 1'b0;
      epc_d      = pc_aligned;
`endif
    end else if (bus.We) begin
      case (bus.A2)
        RegSr: begin
          im_d  = bus.DIn[SrImLo +: 6];
          exl_d = bus.DIn[SrExl];
          ie_d  = bus.DIn[SrIe];
        end
        RegEpc:  epc_d = bus.DIn;
        default: ;
      endcase
    end

    // Entry wins over eret; otherwise eret overrides an mtc0 EXL write.
    if (bus.EXLClr && !int_req) begin
      exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  always_comb begin
    case (bus.A1)
      RegSr:    bus.DOut = pack_sr(im_q, exl_q, ie_q);
      RegCause: bus.DOut = pack_cause(bd_q, ip_q, exc_code_q);
      RegEpc:   bus.DOut = epc_q;
      RegPrid:  bus.DOut = PridValue;
      default:  bus.DOut = '0;
    endcase
  end

  assign bus.IntReq = int_req;
  assign bus.EPC    = epc_q;

endmodule

// File: tb/tb_cp0.sv
// Directed self-checking bench for cp0.
module tb_cp0;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;
  logic [31:0] d;

  cp0_if bus ();

  cp0 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.We      = 1'b0;
    bus.A2      = 5'd0;
    bus.DIn     = 32'd0;
    bus.ExcReq  = 1'b0;
    bus.ExcCode = 5'd0;
    bus.BD      = 1'b0;
    bus.EXLClr  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    bus.A1 = a;
    #1;
    v = bus.DOut;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    bus.HWInt = 6'd0;
    bus.PC    = 32'd0;
    bus.A1    = 5'd0;
    tick();
    rd(5'd12, d); tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_sr: got %h want %h", d, 32'h0); end
    rd(5'd13, d); tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_cause: got %h want %h", d, 32'h0); end
    rd(5'd14, d); tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_epc: got %h want %h", d, 32'h0); end
    rd(5'd15, d); tests_run++;
    if (d !== 32'h2019_1119) begin tests_failed++; $display("FAIL reset_prid: got %h want %h", d, 32'h2019_1119); end
    rd(5'd3, d); tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_unimpl: got %h want %h", d, 32'h0); end
    reset = 1'b0;
    bus.HWInt = 6'h3F;
    #1; tests_run++;
    if (bus.IntReq !== 1'b0) begin tests_failed++; $display("FAIL reset_intreq: got %b want 0", bus.IntReq); end
    bus.HWInt = 6'd0;
    tick();
  endtask

  task automatic test_mtc0_int();
    idle();
    bus.We = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0401;
    tick();
    idle();
    rd(5'd12, d); tests_run++;
    if (d !== 32'h0000_0401) begin tests_failed++; $display("FAIL sr_write: got %h want %h", d, 32'h401); end
    bus.HWInt = 6'b000001; bus.PC = 32'h0000_3004;
    #1; tests_run++;
    if (bus.IntReq !== 1'b1) begin tests_failed++; $display("FAIL int_same_cycle: got %b want 1", bus.IntReq); end
    tick();
    rd(5'd12, d); tests_run++;
    if (d !== 32'h0000_0403) begin tests_failed++; $display("FAIL int_sr_exl: got %h want %h", d, 32'h403); end
    rd(5'd13, d); tests_run++;
    if (d !== 32'h0000_0400) begin tests_failed++; $display("FAIL int_cause: got %h want %h", d, 32'h400); end
    rd(5'd14, d); tests_run++;
    if (d !== 32'h0000_3004) begin tests_failed++; $display("FAIL int_epc: got %h want %h", d, 32'h3004); end
    tests_run++;
    if (bus.EPC !== 32'h0000_3004) begin tests_failed++; $display("FAIL int_epc_port: got %h want %h", bus.EPC, 32'h3004); end
    tests_run++;
    if (bus.IntReq !== 1'b0) begin tests_failed++; $display("FAIL int_masked_by_exl: got %b want 0", bus.IntReq); end
  endtask

  task automatic test_exception();
    bus.HWInt = 6'd0; bus.EXLClr = 1'b1;
    tick();
    idle();
    rd(5'd12, d); tests_run++;
    if (d !== 32'h0000_0401) begin tests_failed++; $display("FAIL eret_sr: got %h want %h", d, 32'h401); end
    bus.ExcReq = 1'b1; bus.ExcCode = 5'd10; bus.PC = 32'h0000_3008;
    #1; tests_run++;
    if (bus.IntReq !== 1'b1) begin tests_failed++; $display("FAIL exc_intreq: got %b want 1", bus.IntReq); end
    tick();
    idle();
    rd(5'd13, d); tests_run++;
    if (d !== 32'h0000_0028) begin tests_failed++; $display("FAIL exc_cause: got %h want %h", d, 32'h28); end
    rd(5'd14, d); tests_run++;
    if (d !== 32'h0000_3008) begin tests_failed++; $display("FAIL exc_epc: got %h want %h", d, 32'h3008); end
    bus.EXLClr = 1'b1;
    tick();
    idle();
    bus.HWInt = 6'b000001; bus.ExcReq = 1'b1; bus.ExcCode = 5'd10; bus.PC = 32'h0000_300B;
    tick();
    idle();
    rd(5'd13, d); tests_run++;
    if (d !== 32'h0000_0400) begin tests_failed++; $display("FAIL exc_int_priority: got %h want %h", d, 32'h400); end
    rd(5'd14, d); tests_run++;
    if (d !== 32'h0000_3008) begin tests_failed++; $display("FAIL exc_epc_align: got %h want %h", d, 32'h3008); end
  endtask

  task automatic test_exl_mask();
    for (int i = 0; i < 4; i++) begin
      bus.HWInt  = (i % 2 == 1) ? 6'h3F : 6'h01;
      bus.ExcReq = (i >= 2);
      bus.PC     = 32'h0000_5000;
      #1; tests_run++;
      if (bus.IntReq !== 1'b0) begin tests_failed++; $display("FAIL exl_mask_%0d: got %b want 0", i, bus.IntReq); end
      tick();
    end
    idle();
    rd(5'd14, d); tests_run++;
    if (d !== 32'h0000_3008) begin tests_failed++; $display("FAIL exl_epc_held: got %h want %h", d, 32'h3008); end
    bus.HWInt = 6'b000001; bus.EXLClr = 1'b1;
    tick();
    idle();
    rd(5'd12, d); tests_run++;
    if (d !== 32'h0000_0401) begin tests_failed++; $display("FAIL exl_cleared: got %h want %h", d, 32'h401); end
    tests_run++;
    if (bus.IntReq !== 1'b1) begin tests_failed++; $display("FAIL pending_fires: got %b want 1", bus.IntReq); end
    bus.PC = 32'h0000_3020;
    tick();
    rd(5'd14, d); tests_run++;
    if (d !== 32'h0000_3020) begin tests_failed++; $display("FAIL pending_epc: got %h want %h", d, 32'h3020); end
  endtask

  task automatic test_we_collision();
    bus.HWInt = 6'd0; bus.EXLClr = 1'b1;
    tick();
    idle();
    bus.HWInt = 6'b000001; bus.We = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_FC00;
    #1; tests_run++;
    if (bus.IntReq !== 1'b1) begin tests_failed++; $display("FAIL coll_intreq: got %b want 1", bus.IntReq); end
    tick();
    idle();
    rd(5'd12, d); tests_run++;
    if (d !== 32'h0000_0403) begin tests_failed++; $display("FAIL coll_sr: got %h want %h", d, 32'h403); end
    bus.HWInt = 6'd0; bus.We = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0C03; bus.EXLClr = 1'b1;
    tick();
    idle();
    rd(5'd12, d); tests_run++;
    if (d !== 32'h0000_0C01) begin tests_failed++; $display("FAIL exlclr_wins: got %h want %h", d, 32'hC01); end
  endtask

  task automatic test_mtc0_misc();
    bus.We = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h1234_5678;
    tick();
    idle();
    rd(5'd14, d); tests_run++;
    if (d !== 32'h1234_5678) begin tests_failed++; $display("FAIL epc_write: got %h want %h", d, 32'h12345678); end
    bus.We = 1'b1; bus.A2 = 5'd13; bus.DIn = 32'hFFFF_FFFF;
    tick();
    idle();
    rd(5'd13, d); tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL cause_ro: got %h want %h", d, 32'h0); end
    bus.We = 1'b1; bus.A2 = 5'd15; bus.DIn = 32'h0;
    tick();
    idle();
    rd(5'd15, d); tests_run++;
    if (d !== 32'h2019_1119) begin tests_failed++; $display("FAIL prid_ro: got %h want %h", d, 32'h20191119); end
    bus.We = 1'b1; bus.A2 = 5'd3; bus.DIn = 32'hFFFF_FFFF;
    tick();
    idle();
    rd(5'd3, d); tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL other_dropped: got %h want %h", d, 32'h0); end
    rd(5'd12, d); tests_run++;
    if (d !== 32'h0000_0C01) begin tests_failed++; $display("FAIL sr_untouched: got %h want %h", d, 32'hC01); end
  endtask

  task automatic test_bd();
    logic [31:0] exp_epc;
    logic [31:0] exp_cause;
`ifdef CP0_BD_EN
    exp_epc   = 32'h0000_300C;
    exp_cause = 32'h8000_0010;
`else
    exp_epc   = 32'h0000_3010;
    exp_cause = 32'h0000_0010;
`endif
    bus.BD = 1'b1; bus.ExcReq = 1'b1; bus.ExcCode = 5'd4; bus.PC = 32'h0000_3010;
    tick();
    idle();
    rd(5'd14, d); tests_run++;
    if (d !== exp_epc) begin tests_failed++; $display("FAIL bd_epc: got %h want %h", d, exp_epc); end
    rd(5'd13, d); tests_run++;
    if (d !== exp_cause) begin tests_failed++; $display("FAIL bd_cause: got %h want %h", d, exp_cause); end
  endtask

  task automatic test_async_reset();
    bus.HWInt = 6'h3F; bus.ExcReq = 1'b1; bus.ExcCode = 5'd7; bus.PC = 32'h0000_4000;
    @(negedge clk);
    #2;
    reset = 1'b1;
    rd(5'd12, d); tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL async_sr: got %h want %h", d, 32'h0); end
    rd(5'd13, d); tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL async_cause: got %h want %h", d, 32'h0); end
    rd(5'd14, d); tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL async_epc: got %h want %h", d, 32'h0); end
    rd(5'd15, d); tests_run++;
    if (d !== 32'h2019_1119) begin tests_failed++; $display("FAIL async_prid: got %h want %h", d, 32'h20191119); end
    tick();
    rd(5'd14, d); tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_blocks_entry: got %h want %h", d, 32'h0); end
    idle();
    reset = 1'b0;
    #1; tests_run++;
    if (bus.IntReq !== 1'b0) begin tests_failed++; $display("FAIL post_reset_intreq: got %b want 0", bus.IntReq); end
    rd(5'd12, d); tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL post_reset_sr: got %h want %h", d, 32'h0); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_mtc0_int();
    test_exception();
    test_exl_mask();
    test_we_collision();
    test_mtc0_misc();
    test_bd();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
